// File: rtl/rfic_gpo_pkg.sv
// Shared defaults for the RFIC GPO conditioner: line count, field widths and
// the counter-select width derived from the line count.
package rfic_gpo_pkg;

  localparam int DEF_N_LINES = 8;
  localparam int DEF_LEN_W   = 8;
  localparam int DEF_CNT_W   = 16;

  // Select width for an n-entry mux; at least one bit so a single-line
  // build still has a legal port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_SEL_W = sel_width(DEF_N_LINES);

endpackage

// File: rtl/rfic_gpo_conditioner_if.sv
// Bus between the GPO conditioner and its user.
// - The master drives the pins, the configuration and the clears.
// - The slave (the conditioner) returns the filtered lines, the flags and the
//   counter readback.
interface rfic_gpo_conditioner_if #(
  parameter int N_LINES = rfic_gpo_pkg::DEF_N_LINES,
  parameter int LEN_W   = rfic_gpo_pkg::DEF_LEN_W,
  parameter int CNT_W   = rfic_gpo_pkg::DEF_CNT_W
);

  localparam int SEL_W = rfic_gpo_pkg::sel_width(N_LINES);

  logic [N_LINES-1:0] gpo_in;
  logic [LEN_W-1:0]   cfg_len;
  logic [N_LINES-1:0] evt_clr;
  logic               cnt_clr;
  logic [SEL_W-1:0]   cnt_sel;
  logic [N_LINES-1:0] gpo_out;
  logic [N_LINES-1:0] rise_evt;
  logic [N_LINES-1:0] fall_evt;
  logic [CNT_W-1:0]   cnt_rd;

  modport master (
    output gpo_in, cfg_len, evt_clr, cnt_clr, cnt_sel,
    input  gpo_out, rise_evt, fall_evt, cnt_rd
  );

  modport slave (
    input  gpo_in, cfg_len, evt_clr, cnt_clr, cnt_sel,
    output gpo_out, rise_evt, fall_evt, cnt_rd
  );

endinterface

// File: rtl/rfic_gpo_conditioner_debounce_line.sv
// One GPO line: 2-flop synchroniser followed by a stable-count debouncer.
// The filtered level changes only after the synchronised pin has disagreed
// with it for cfg_len+1 consecutive cycles. The rise/fall pulses are
// combinational and valid in the cycle before the filtered level changes, so
// a register fed by them updates on the same edge as the level.
module gpo_debounce_line #(
  parameter int LEN_W = rfic_gpo_pkg::DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pin,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             level,
  output logic             rise,
  output logic             fall
);

  logic             s1;
  logic             s2;
  logic             q;
  logic [LEN_W-1:0] c;
  logic             accept;

  // The disagreement has lasted long enough to be taken as a real edge.
  assign accept = (s2 != q) && (c >= cfg_len);
  assign rise   = accept && s2;
  assign fall   = accept && !s2;
  assign level  = q;

  // Bring the asynchronous pin into the clk domain; nothing sits between s1 and s2.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so s2 takes the old s1, not the new one.
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

  // Stable-count filter. c never exceeds cfg_len, so it cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
      c <= '0;
    end else if (s2 == q) begin
      c <= '0;
    end else if (accept) begin
      q <= s2;
      c <= '0;
    end else begin
      c <= c + 1'b1;
    end
  end

endmodule

// File: rtl/rfic_gpo_conditioner.sv
// Conditions the AD9361 GPO lines of both RFICs before they reach the line
// matrix. Bit 0 is RFIC 0 GPO0.
// - Each line is synchronised and debounced by gpo_debounce_line.
// - This level adds sticky edge flags, saturating rising-edge counters and a
//   registered counter readback.
module rfic_gpo_conditioner
  import rfic_gpo_pkg::*;
#(
  parameter int N_LINES = DEF_N_LINES,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic                  clk,
  input logic                  rst,
  rfic_gpo_conditioner_if.slave bus
);

  logic [N_LINES-1:0] level;
  logic [N_LINES-1:0] rise_p;
  logic [N_LINES-1:0] fall_p;
  logic [N_LINES-1:0] rise_q;
  logic [N_LINES-1:0] fall_q;
  logic [CNT_W-1:0]   cnt [N_LINES];
  logic [CNT_W-1:0]   cnt_rd_q;

  for (genvar i = 0; i < N_LINES; i++) begin : g_line
    gpo_debounce_line #(.LEN_W(LEN_W)) u_line (
      .clk     (clk),
      .rst     (rst),
      .pin     (bus.gpo_in[i]),
      .cfg_len (bus.cfg_len),
      .level   (level[i]),
      .rise    (rise_p[i]),
      .fall    (fall_p[i])
    );
  end

  // Sticky flags. The OR of the pulse comes after the clear, so a set
  // arriving in the clear cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= (rise_q & ~bus.evt_clr) | rise_p;
      fall_q <= (fall_q & ~bus.evt_clr) | fall_p;
    end
  end

  // Rising-edge counters. They saturate at all-ones. A clear coincident with
  // a rise leaves a count of one.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_LINES; i++) begin
      // NOTE: the counter array is reset element by element because its contents are software-visible.
      if (rst) begin
        cnt[i] <= '0;
      end else if (bus.cnt_clr) begin
        cnt[i] <= rise_p[i] ? CNT_W'(1) : '0;
      end else if (rise_p[i] && !(&cnt[i])) begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Registered readback of the selected counter; a select past the last line reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_rd_q <= '0;
    end else if (int'(bus.cnt_sel) < N_LINES) begin
      cnt_rd_q <= cnt[bus.cnt_sel];
    end else begin
      cnt_rd_q <= '0;
    end
  end

  assign bus.gpo_out  = level;
  assign bus.rise_evt = rise_q;
  assign bus.fall_evt = fall_q;
  assign bus.cnt_rd   = cnt_rd_q;

endmodule

// File: tb/tb_rfic_gpo_conditioner.sv
// Directed bench for rfic_gpo_conditioner.
// - One default-width instance covers reset, filtering, flags and readback.
// - A second instance with 4-bit counters covers saturation.
// - Inputs change 1 ns after a rising edge, and outputs are sampled at the same point.
module tb_rfic_gpo_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rfic_gpo_conditioner_if bif ();
  rfic_gpo_conditioner_if #(.CNT_W(4)) sif ();

  rfic_gpo_conditioner dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  rfic_gpo_conditioner #(.CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.gpo_in  = '0; bif.cfg_len = '0; bif.evt_clr = '0; bif.cnt_clr = 1'b0; bif.cnt_sel = '0;
    sif.gpo_in  = '0; sif.cfg_len = '0; sif.evt_clr = '0; sif.cnt_clr = 1'b0; sif.cnt_sel = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reset with all pins high and L=4: outputs are 0 throughout reset, then
  // all lines rise together at edge 7 after deassertion.
  task automatic test_reset();
    idle_inputs();
    bif.gpo_in  = 8'hFF;
    bif.cfg_len = 8'd4;
    rst = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      total++;
      if (bif.gpo_out !== 8'h00 || bif.rise_evt !== 8'h00 || bif.fall_evt !== 8'h00 || bif.cnt_rd !== 16'd0) begin
        bad++;
        $display("FAIL reset_hold edge=%0d got out=%h rise=%h fall=%h rd=%0d want all 0",
                 e, bif.gpo_out, bif.rise_evt, bif.fall_evt, bif.cnt_rd);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      logic [7:0] exp;
      tick();
      exp = (e >= 7) ? 8'hFF : 8'h00;
      total++;
      if (bif.gpo_out !== exp || bif.rise_evt !== exp) begin
        bad++;
        $display("FAIL reset_release edge=%0d got out=%h rise=%h want %h", e, bif.gpo_out, bif.rise_evt, exp);
      end
    end
  endtask

  // L=0 on line 3: the output follows the pin three edges after it is driven,
  // and the line 3 counter reads back one edge after each counted rise.
  task automatic test_pass_through();
    logic       v;
    logic [2:0] pipe;
    logic       prev;
    int         exp_cnt;
    int         exp_rd;
    do_reset();
    bif.cfg_len = 8'd0;
    bif.cnt_sel = 3'd3;
    v = 1'b0; pipe = '0; prev = 1'b0; exp_cnt = 0;
    for (int t = 0; t < 40; t++) begin
      if (t % 5 == 0) v = ~v;
      bif.gpo_in[3] = v;
      tick();
      pipe   = {pipe[1:0], v};
      exp_rd = exp_cnt;
      if (pipe[2] && !prev) exp_cnt++;
      prev = pipe[2];
      total++;
      if (bif.gpo_out !== {4'b0, pipe[2], 3'b0} || bif.cnt_rd !== 16'(exp_rd)) begin
        bad++;
        $display("FAIL pass_through t=%0d got out=%h rd=%0d want out=%h rd=%0d",
                 t, bif.gpo_out, bif.cnt_rd, {4'b0, pipe[2], 3'b0}, exp_rd);
      end
    end
    // Rises were driven at t=0,10,20,30.
    total++;
    if (bif.cnt_rd !== 16'd4) begin
      bad++;
      $display("FAIL pass_through_count got %0d want 4", bif.cnt_rd);
    end
  endtask

  // L=5 on line 0. Disagreements shorter than 6 cycles are rejected, and a
  // 6-cycle pulse passes.
  task automatic test_glitch_reject();
    do_reset();
    bif.cfg_len = 8'd5;
    // 5-cycle pulse
    bif.gpo_in[0] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bif.gpo_in[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (bif.gpo_out[0] !== 1'b0 || bif.rise_evt[0] !== 1'b0) begin
        bad++;
        $display("FAIL glitch5 i=%0d got out=%b rise=%b want 0 0", i, bif.gpo_out[0], bif.rise_evt[0]);
      end
    end
    // 6-cycle pulse driven after edge n: rises at edge n+8, and falls back at
    // n+14 after its own 6-cycle low.
    bif.gpo_in[0] = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      logic exp_out;
      logic exp_rise;
      logic exp_fall;
      tick();
      if (i == 6) bif.gpo_in[0] = 1'b0;
      exp_out  = (i >= 8) && (i < 14);
      exp_rise = (i >= 8);
      exp_fall = (i >= 14);
      total++;
      if (bif.gpo_out[0] !== exp_out || bif.rise_evt[0] !== exp_rise || bif.fall_evt[0] !== exp_fall) begin
        bad++;
        $display("FAIL glitch6 edge=%0d got out=%b rise=%b fall=%b want %b %b %b",
                 i, bif.gpo_out[0], bif.rise_evt[0], bif.fall_evt[0], exp_out, exp_rise, exp_fall);
      end
    end
    // 4 high / 1 low / 4 high chatter
    do_reset();
    bif.cfg_len = 8'd5;
    for (int i = 0; i < 9; i++) begin
      bif.gpo_in[0] = (i != 4);
      tick();
    end
    bif.gpo_in[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (bif.gpo_out[0] !== 1'b0 || bif.rise_evt[0] !== 1'b0) begin
        bad++;
        $display("FAIL chatter i=%0d got out=%b rise=%b want 0 0", i, bif.gpo_out[0], bif.rise_evt[0]);
      end
    end
  endtask

  // The clear arrives on the same edge as a filtered rise on line 2 and the
  // set wins; the clear on the next edge takes effect.
  task automatic test_sticky_clear_race();
    do_reset();
    bif.cfg_len   = 8'd0;
    bif.gpo_in[2] = 1'b1;
    tick();
    tick();
    bif.evt_clr[2] = 1'b1;
    tick();
    total++;
    if (bif.rise_evt[2] !== 1'b1 || bif.gpo_out[2] !== 1'b1) begin
      bad++;
      $display("FAIL clear_race got rise=%b out=%b want 1 1", bif.rise_evt[2], bif.gpo_out[2]);
    end
    tick();
    bif.evt_clr[2] = 1'b0;
    total++;
    if (bif.rise_evt[2] !== 1'b0) begin
      bad++;
      $display("FAIL clear_after got rise=%b want 0", bif.rise_evt[2]);
    end
  endtask

  // The 4-bit counters stop at 15 after 20 rises. A clear coincident with a
  // rise leaves 1.
  task automatic test_counter_saturation();
    do_reset();
    sif.cfg_len = 8'd0;
    sif.cnt_sel = 3'd1;
    for (int r = 0; r < 20; r++) begin
      sif.gpo_in[1] = 1'b1; tick(); tick();
      sif.gpo_in[1] = 1'b0; tick(); tick();
    end
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (sif.cnt_rd !== 4'd15 || sif.gpo_out[1] !== 1'b0) begin
        bad++;
        $display("FAIL saturate i=%0d got rd=%0d out=%b want 15 0", i, sif.cnt_rd, sif.gpo_out[1]);
      end
    end
    sif.gpo_in[1] = 1'b1;
    tick();
    tick();
    sif.cnt_clr = 1'b1;
    tick();
    sif.cnt_clr = 1'b0;
    total++;
    if (sif.cnt_rd !== 4'd15) begin
      bad++;
      $display("FAIL clr_rise_edge got rd=%0d want 15", sif.cnt_rd);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (sif.cnt_rd !== 4'd1) begin
        bad++;
        $display("FAIL clr_rise i=%0d got rd=%0d want 1", i, sif.cnt_rd);
      end
    end
  endtask

  // With L=200, a disagreement on line 5 runs for 50 counted cycles. L is
  // then dropped to 10 and the line updates on the next edge.
  task automatic test_lower_len();
    do_reset();
    bif.cfg_len   = 8'd200;
    bif.gpo_in[5] = 1'b1;
    for (int i = 0; i < 52; i++) tick();
    total++;
    if (bif.gpo_out[5] !== 1'b0) begin
      bad++;
      $display("FAIL lower_len_before got out=%b want 0", bif.gpo_out[5]);
    end
    bif.cfg_len = 8'd10;
    tick();
    total++;
    if (bif.gpo_out[5] !== 1'b1 || bif.rise_evt[5] !== 1'b1) begin
      bad++;
      $display("FAIL lower_len_after got out=%b rise=%b want 1 1", bif.gpo_out[5], bif.rise_evt[5]);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_glitch_reject();
    test_sticky_clear_race();
    test_counter_saturation();
    test_lower_len();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
